// File: rtl/sdcmd_resp.sv
// rtl/sdcmd_resp.sv - SD card-side command receiver and response transmitter
// Optional CRC7/end-bit check on received frames: define SDCMD_RESP_CRCCHK_EN.
module sdcmd_resp #(
  parameter int NCR = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sdclk,
  input  logic        sdcmd_in,
  output logic        sdcmd_out,
  output logic        sdcmd_oe,
  output logic        busy,
  output logic        cmd_valid,
  output logic [5:0]  cmd_idx,
  output logic [31:0] cmd_arg,
  output logic        cmd_crc_err,
  input  logic        resp_start,
  input  logic        resp_skip,
  input  logic [5:0]  resp_idx,
  input  logic [31:0] resp_arg,
  input  logic        resp_nocrc
);

  typedef enum logic [2:0] {
    S_IDLE, S_RX, S_CHECK, S_WAIT, S_GAP, S_TX
  } state_t;

  localparam logic [6:0] NCR_W = 7'(NCR);

  function automatic logic [6:0] crc7_next(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  state_t      state;
  logic [2:0]  clk_sync;
  logic [1:0]  cmd_sync;
  logic [47:0] rx_sr;
  logic [5:0]  rx_cnt;
  logic [6:0]  crc;
  logic [6:0]  fall_cnt;
  logic [39:0] tx_sr;
  logic [5:0]  tx_cnt;
  logic        nocrc_q;
  logic        tx_bit;
  logic        drive;
  logic        unused_bits;

  wire rise    = clk_sync[1] & ~clk_sync[2];
  wire fall    = ~clk_sync[1] & clk_sync[2];
  wire cmd_bit = cmd_sync[1];

  // Bits 0..39 come from the header, 40..46 from the running CRC, 47 is the end bit.
  always_comb begin
    tx_bit = 1'b1;
    if (tx_cnt < 6'd40)
      tx_bit = tx_sr[39];
    else if (tx_cnt < 6'd47)
      tx_bit = nocrc_q | crc[6];
  end

  assign drive = fall && ((state == S_GAP && fall_cnt >= NCR_W) ||
                          (state == S_TX && tx_cnt != 6'd48));

`ifdef SDCMD_RESP_CRCCHK_EN
  wire crc_ok = (rx_sr[7:1] == crc) && rx_sr[0];
  assign unused_bits = rx_sr[47];
`else
  assign cmd_crc_err = 1'b0;
  assign unused_bits = ^{rx_sr[47], rx_sr[7:0]};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      clk_sync  <= 3'b000;
      cmd_sync  <= 2'b11;
      rx_sr     <= '0;
      rx_cnt    <= '0;
      crc       <= '0;
      fall_cnt  <= '0;
      tx_sr     <= '0;
      tx_cnt    <= '0;
      nocrc_q   <= 1'b0;
      sdcmd_out <= 1'b1;
      sdcmd_oe  <= 1'b0;
      busy      <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_idx   <= '0;
      cmd_arg   <= '0;
`ifdef SDCMD_RESP_CRCCHK_EN
      cmd_crc_err <= 1'b0;
`endif
    end else begin
      clk_sync <= {clk_sync[1:0], sdclk};
      cmd_sync <= {cmd_sync[0], sdcmd_in};
`ifdef SDCMD_RESP_CRCCHK_EN
      cmd_crc_err <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (rise && !cmd_bit) begin
            state  <= S_RX;
            busy   <= 1'b1;
            rx_sr  <= {rx_sr[46:0], 1'b0};
            rx_cnt <= 6'd1;
            crc    <= crc7_next(7'h00, 1'b0);
          end
        end
        S_RX: begin
          if (rise) begin
            rx_sr  <= {rx_sr[46:0], cmd_bit};
            rx_cnt <= rx_cnt + 6'd1;
            if (rx_cnt < 6'd40)
              crc <= crc7_next(crc, cmd_bit);
            if (rx_cnt == 6'd47) begin
              state    <= S_CHECK;
              fall_cnt <= '0;
            end
          end
        end
        S_CHECK: begin
          if (fall && fall_cnt < NCR_W)
            fall_cnt <= fall_cnt + 7'd1;
          if (!rx_sr[46]) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
`ifdef SDCMD_RESP_CRCCHK_EN
          else if (!crc_ok) begin
            cmd_crc_err <= 1'b1;
            state       <= S_IDLE;
            busy        <= 1'b0;
          end
`endif
          else begin
            cmd_idx   <= rx_sr[45:40];
            cmd_arg   <= rx_sr[39:8];
            cmd_valid <= 1'b1;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          // The NCR gap keeps counting here so a slow user does not stretch it.
          if (fall && fall_cnt < NCR_W)
            fall_cnt <= fall_cnt + 7'd1;
          if (resp_skip) begin
            cmd_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end else if (resp_start) begin
            cmd_valid <= 1'b0;
            tx_sr     <= {2'b00, (resp_nocrc ? 6'h3f : resp_idx), resp_arg};
            nocrc_q   <= resp_nocrc;
            crc       <= '0;
            tx_cnt    <= '0;
            state     <= S_GAP;
          end
        end
        S_GAP: begin
          if (drive)
            state <= S_TX;
          else if (fall && fall_cnt < NCR_W)
            fall_cnt <= fall_cnt + 7'd1;
        end
        S_TX: begin
          if (fall && tx_cnt == 6'd48) begin
            sdcmd_oe  <= 1'b0;
            sdcmd_out <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (drive) begin
        sdcmd_out <= tx_bit;
        sdcmd_oe  <= 1'b1;
        tx_cnt    <= tx_cnt + 6'd1;
        if (tx_cnt < 6'd40) begin
          crc   <= crc7_next(crc, tx_sr[39]);
          tx_sr <= {tx_sr[38:0], 1'b0};
        end else begin
          crc <= {crc[5:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_sdcmd_resp.sv
// tb/tb_sdcmd_resp.sv - randomized self-checking bench for sdcmd_resp
// Honours SDCMD_RESP_CRCCHK_EN the same way the design does.
module tb_sdcmd_resp;

  localparam int NCR = 2;
`ifdef SDCMD_RESP_CRCCHK_EN
  localparam bit CRCCHK = 1'b1;
`else
  localparam bit CRCCHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sdclk = 1'b0;
  logic        sdcmd_in = 1'b1;
  logic        sdcmd_out, sdcmd_oe, busy, cmd_valid, cmd_crc_err;
  logic [5:0]  cmd_idx;
  logic [31:0] cmd_arg;
  logic        resp_start = 1'b0;
  logic        resp_skip = 1'b0;
  logic [5:0]  resp_idx = '0;
  logic [31:0] resp_arg = '0;
  logic        resp_nocrc = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  int err_pulses = 0;

  sdcmd_resp #(.NCR(NCR)) dut (
    .clk(clk), .rst(rst), .sdclk(sdclk), .sdcmd_in(sdcmd_in),
    .sdcmd_out(sdcmd_out), .sdcmd_oe(sdcmd_oe), .busy(busy),
    .cmd_valid(cmd_valid), .cmd_idx(cmd_idx), .cmd_arg(cmd_arg),
    .cmd_crc_err(cmd_crc_err), .resp_start(resp_start), .resp_skip(resp_skip),
    .resp_idx(resp_idx), .resp_arg(resp_arg), .resp_nocrc(resp_nocrc)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (cmd_crc_err) err_pulses++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1.
  function automatic logic [6:0] crc7_ref(input logic [39:0] d);
    logic [46:0] m;
    m = {d, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (m[i]) m = m ^ (47'h89 << (i - 7));
    return m[6:0];
  endfunction

  // bad: 0 clean, 1 corrupted CRC, 2 end bit cleared
  function automatic logic [47:0] mk_frame(input logic tx, input logic [5:0] idx,
                                           input logic [31:0] arg, input int bad);
    logic [39:0] head;
    logic [6:0]  c;
    head = {1'b0, tx, idx, arg};
    c = crc7_ref(head);
    if (bad == 1) c = c ^ 7'h01;
    return {head, c, (bad != 2)};
  endfunction

  function automatic logic [47:0] mk_resp(input logic [5:0] idx, input logic [31:0] arg,
                                          input logic nocrc);
    logic [39:0] head;
    head = {2'b00, (nocrc ? 6'h3f : idx), arg};
    return {head, (nocrc ? 7'h7f : crc7_ref(head)), 1'b1};
  endfunction

  // One sdclk period: host drives its bit after the fall and samples just before the rise.
  task automatic sd_cycle(input logic hb, output logic so, output logic sd);
    sdclk = 1'b0;
    sdcmd_in = hb;
    #72;
    so = sdcmd_oe;
    sd = sdcmd_out;
    #8;
    sdclk = 1'b1;
    #80;
  endtask

  // action: 0 skip, 1 respond after 'delay' sdclk cycles; rst_bit >= 0 resets mid-response
  task automatic run_cmd(input string tag, input logic [47:0] frame, input int action,
                         input int delay, input logic [5:0] ridx, input logic [31:0] rarg,
                         input logic rnocrc, input int rst_bit);
    logic o, d, oe_ok, bad, exp_valid;
    logic [47:0] got, exp;
    int err_base, released, exp_rel;
    bit started;
    err_base = err_pulses;
    for (int i = 47; i >= 0; i--) begin
      sd_cycle(frame[i], o, d);
      if (i == 47) check({tag, " busy_rx"}, busy, 1'b1);
    end
    bad = (frame[7:1] != crc7_ref(frame[47:8])) || !frame[0];
    exp_valid = frame[46] && !(CRCCHK && bad);
    check({tag, " valid"}, cmd_valid, exp_valid);
    check({tag, " crc_err"}, err_pulses - err_base, (frame[46] && bad && CRCCHK) ? 1 : 0);
    if (!exp_valid) begin
      check({tag, " busy_drop"}, busy, 1'b0);
      return;
    end
    check({tag, " idx"}, cmd_idx, frame[45:40]);
    check({tag, " arg"}, cmd_arg, frame[39:8]);
    if (action == 0) begin
      resp_skip = 1'b1;
      sd_cycle(1'b1, o, d);
      resp_skip = 1'b0;
      check({tag, " skip_oe"}, o, 1'b0);
      check({tag, " skip_busy"}, busy, 1'b0);
      check({tag, " skip_valid"}, cmd_valid, 1'b0);
      return;
    end
    released = 0;
    for (int k = 0; k < delay; k++) begin
      sd_cycle(1'b1, o, d);
      if (!o) released++;
    end
    resp_idx = ridx;
    resp_arg = rarg;
    resp_nocrc = rnocrc;
    resp_start = 1'b1;
    started = 1'b0;
    for (int k = 0; k < 100 && !started; k++) begin
      sd_cycle(1'b1, o, d);
      if (o) started = 1'b1;
      else released++;
    end
    if (!started) begin
      check({tag, " start_timeout"}, 1'b0, 1'b1);
      resp_start = 1'b0;
      return;
    end
    check({tag, " valid_drop"}, cmd_valid, 1'b0);
    exp_rel = (delay > NCR) ? delay : NCR;
    check({tag, " gap"}, released, exp_rel);
    got = '0;
    got[47] = d;
    oe_ok = 1'b1;
    for (int k = 46; k >= 0; k--) begin
      sd_cycle(1'b1, o, d);
      got[k] = d;
      oe_ok &= o;
      if (47 - k == rst_bit) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        check({tag, " rst_oe"}, sdcmd_oe, 1'b0);
        check({tag, " rst_out"}, sdcmd_out, 1'b1);
        check({tag, " rst_busy"}, busy, 1'b0);
        rst = 1'b0;
        resp_start = 1'b0;
        @(negedge clk);
        return;
      end
    end
    exp = mk_resp(ridx, rarg, rnocrc);
    check({tag, " resp"}, got, exp);
    check({tag, " resp_oe"}, oe_ok, 1'b1);
    sd_cycle(1'b1, o, d);
    check({tag, " rel_oe"}, o, 1'b0);
    check({tag, " rel_out"}, d, 1'b1);
    check({tag, " end_busy"}, busy, 1'b0);
    resp_start = 1'b0;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic        tx, nc;
    logic [5:0]  ix, rix;
    logic [31:0] ag, rag;
    int          bk, act, dly;
    repeat (4) @(negedge clk);
    check("reset oe", sdcmd_oe, 1'b0);
    check("reset out", sdcmd_out, 1'b1);
    check("reset busy", busy, 1'b0);
    check("reset valid", cmd_valid, 1'b0);
    check("reset idx", cmd_idx, 6'd0);
    check("reset arg", cmd_arg, 32'd0);
    check("reset crc_err", cmd_crc_err, 1'b0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    run_cmd("cmd0_skip", mk_frame(1'b1, 6'd0, 32'h0, 0), 0, 0, 6'd0, 32'h0, 1'b0, -1);
    run_cmd("cmd8_r7", mk_frame(1'b1, 6'd8, 32'h1AA, 0), 1, 0, 6'd8, 32'h1AA, 1'b0, -1);
    run_cmd("cmd17_endbit", mk_frame(1'b1, 6'd17, 32'h0, 2), 0, 0, 6'd0, 32'h0, 1'b0, -1);
    run_cmd("cmd17_crcbad", mk_frame(1'b1, 6'd17, 32'h0, 1), 0, 0, 6'd0, 32'h0, 1'b0, -1);
    run_cmd("r3_late", mk_frame(1'b1, 6'd41, 32'h40FF8000, 0), 1, 10, 6'd0, 32'h80FF8000, 1'b1, -1);
    run_cmd("tx_rst", mk_frame(1'b1, 6'd8, 32'h1AA, 0), 1, 0, 6'd8, 32'h1AA, 1'b0, 20);
    run_cmd("cmd0_after_rst", mk_frame(1'b1, 6'd0, 32'h0, 0), 0, 0, 6'd0, 32'h0, 1'b0, -1);
    run_cmd("txbit0", mk_frame(1'b0, 6'd8, 32'h1AA, 0), 0, 0, 6'd0, 32'h0, 1'b0, -1);

    for (int n = 0; n < 16; n++) begin
      tx  = ($urandom_range(0, 7) != 0);
      ix  = 6'($urandom);
      ag  = $urandom;
      bk  = $urandom_range(0, 3);
      if (bk == 3) bk = 0;
      act = ($urandom_range(0, 3) != 0) ? 1 : 0;
      dly = $urandom_range(0, 5);
      rix = 6'($urandom);
      rag = $urandom;
      nc  = ($urandom_range(0, 3) == 0);
      run_cmd($sformatf("rand%0d", n), mk_frame(tx, ix, ag, bk), act, dly, rix, rag, nc, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
